// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the LSU memory master and its alignment datapath.
package lsu_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic            store;
        logic [2:0]      funct3;
        logic [2:0]      offset;
        logic [XLEN-1:0] wdata;
    } lsu_op_t;

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

    function automatic logic [XLEN-1:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Unsigned widths exist only for loads; 111 is never legal.
    function automatic logic funct3_illegal(input logic store, input logic [2:0] funct3);
        return (funct3 == 3'b111) || (store && funct3[2]);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: extracts/extends load data and merges store bytes into the old doubleword.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] old_word_i,
    input  logic [2:0]      offset_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] store_word_o,
    output logic [XLEN-1:0] load_data_o
);

    logic [5:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] lane_mask;

    assign shamt     = {offset_i, 3'b000};
    assign shifted   = old_word_i >> shamt;
    assign lane_mask = size_mask(funct3_i) << shamt;

    assign store_word_o = (old_word_i & ~lane_mask) | ((wdata_i << shamt) & lane_mask);

    always_comb begin
        load_data_o = '0;
        case (funct3_i)
            F3_B:    load_data_o = {{56{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data_o = {56'd0, shifted[7:0]};
            F3_H:    load_data_o = {{48{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data_o = {48'd0, shifted[15:0]};
            F3_W:    load_data_o = {{32{shifted[31]}}, shifted[31:0]};
            F3_WU:   load_data_o = {32'd0, shifted[31:0]};
            default: load_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator toward data_memory: request checks, read-modify-write for narrow
// stores, and a registered valid/ready response.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned     DEPTH     = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = 64'd0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic [XLEN-1:0] address,
    output logic [XLEN-1:0] WriteData,
    output logic            MemRead,
    output logic            MemWrite,
    input  logic [XLEN-1:0] ReadData
);

    localparam int unsigned     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [XLEN-1:0] SPAN     = 64'(DEPTH) * 64'd8;
    localparam logic [XLEN-1:0] IDX_MASK = (64'd1 << IDX_W) - 64'd1;

    lsu_state_e      state_q, state_d;
    lsu_op_t         op_q, op_d;
    logic [XLEN-1:0] address_q, address_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            mem_rd_q, mem_rd_d;
    logic            mem_wr_q, mem_wr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic [XLEN:0]   rel_diff_c;
    logic [XLEN-1:0] rel_addr_c;
    logic            req_err_c;
    logic [XLEN-1:0] merged_c;
    logic [XLEN-1:0] load_c;

    // Extra bit of the subtraction is the borrow, i.e. addr below BASE_ADDR.
    assign rel_diff_c = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign rel_addr_c = rel_diff_c[XLEN-1:0];
    assign req_err_c  = funct3_illegal(req_store, req_funct3)
                     || ((4'(req_addr[2:0]) & (size_bytes(req_funct3) - 4'd1)) != 4'd0)
                     || rel_diff_c[XLEN]
                     || (rel_addr_c >= SPAN);

    lsu_align u_align (
        .old_word_i   (ReadData),
        .offset_i     (op_q.offset),
        .funct3_i     (op_q.funct3),
        .wdata_i      (op_q.wdata),
        .store_word_o (merged_c),
        .load_data_o  (load_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            address_q   <= '0;
            wdata_q     <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            address_q   <= address_d;
            wdata_q     <= wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Strobes default low so each MemRead/MemWrite lasts exactly one cycle.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        address_d   = address_q;
        wdata_d     = wdata_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d = '{store: req_store, funct3: req_funct3,
                             offset: req_addr[2:0], wdata: req_wdata};
                    if (req_err_c) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = ST_RESP;
                    end else begin
                        address_d = (rel_addr_c >> 3) & IDX_MASK;
                        if (req_store && (req_funct3 == F3_D)) begin
                            wdata_d  = req_wdata;
                            mem_wr_d = 1'b1;
                            state_d  = ST_WR;
                        end else begin
                            mem_rd_d = 1'b1;
                            state_d  = ST_RD;
                        end
                    end
                end
            end
            ST_RD: begin
                if (op_q.store) begin
                    wdata_d  = merged_c;
                    mem_wr_d = 1'b1;
                    state_d  = ST_WR;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = load_c;
                    state_d     = ST_RESP;
                end
            end
            ST_WR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign address   = address_q;
    assign WriteData = wdata_q;
    assign MemRead   = mem_rd_q;
    assign MemWrite  = mem_wr_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master against a behavioural data_memory model.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata, address, WriteData, ReadData;
    logic        MemRead, MemWrite;

    always #5 clk = ~clk;

    lsu_mem_master #(.DEPTH(1024), .BASE_ADDR(64'd0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .address(address), .WriteData(WriteData), .MemRead(MemRead), .MemWrite(MemWrite),
        .ReadData(ReadData)
    );

    logic [63:0] mem [0:1023];
    logic        mem_load;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 64'd0;
            mem[2] <= 64'h8877_6655_4433_2211;
        end else if (MemWrite) begin
            mem[address[9:0]] <= WriteData;
        end
    end

    assign ReadData = (address < 64'd1024) ? mem[address[9:0]] : 64'd0;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   mw_count = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Response scoreboard plus strobe exclusivity, sampled mid-cycle.
    always @(negedge clk) begin
        if (MemWrite) mw_count++;
        if (MemRead || MemWrite) check("rw_excl", 64'(MemRead & MemWrite), 64'd0);
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
                check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input logic [63:0] exp_rd, input logic exp_err,
                         output int lat, output logic [7:0] mr, output logic [7:0] mw,
                         output logic [63:0] wa, output logic [63:0] wdat);
        int n;
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("accept_timeout", 64'd1, 64'd0);
        sb.push_back('{rdata: exp_rd, err: exp_err});
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; mr = '0; mw = '0; wa = '0; wdat = '0;
        do begin
            @(negedge clk);
            lat++;
            if (lat < 8) begin
                mr[lat] = MemRead;
                mw[lat] = MemWrite;
            end
            if (MemWrite) begin
                wa   = address;
                wdat = WriteData;
            end
        end while (!rsp_valid && lat < 20);
        if (!rsp_valid) check("rsp_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic run(input string tag, input logic st, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd,
                       input logic [63:0] exp_rd, input logic exp_err, input int exp_lat,
                       input logic [7:0] exp_mr, input logic [7:0] exp_mw,
                       input logic [63:0] exp_wa, input logic [63:0] exp_wd);
        int          lat;
        logic [7:0]  mr, mw;
        logic [63:0] wa, wdat;
        issue(st, f3, a, wd, exp_rd, exp_err, lat, mr, mw, wa, wdat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_memread"}, 64'(mr), 64'(exp_mr));
        check({tag, "_memwrite"}, 64'(mw), 64'(exp_mw));
        if (exp_mw != 8'd0) begin
            check({tag, "_waddr"}, wa, exp_wa);
            check({tag, "_wdata"}, wdat, exp_wd);
        end
    endtask

    localparam logic [7:0] RD1 = 8'b0000_0010;
    localparam logic [7:0] WR1 = 8'b0000_0010;
    localparam logic [7:0] WR2 = 8'b0000_0100;

    initial begin
        int n;
        int mw_snap;
        rst = 1'b1; mem_load = 1'b1; rsp_ready = 1'b1;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_address", address, 64'd0);
        check("rst_wdata", WriteData, 64'd0);
        check("rst_strobes", 64'({MemRead, MemWrite}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_load = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        run("lb_17",  0, 3'b000, 64'h17, 0, 64'hFFFF_FFFF_FFFF_FF88, 0, 2, RD1, 0, 0, 0);
        run("lbu_17", 0, 3'b100, 64'h17, 0, 64'h88, 0, 2, RD1, 0, 0, 0);
        run("lw_10",  0, 3'b010, 64'h10, 0, 64'h0000_0000_4433_2211, 0, 2, RD1, 0, 0, 0);
        run("lh_16",  0, 3'b001, 64'h16, 0, 64'hFFFF_FFFF_FFFF_8877, 0, 2, RD1, 0, 0, 0);
        run("lhu_16", 0, 3'b101, 64'h16, 0, 64'h8877, 0, 2, RD1, 0, 0, 0);
        run("lw_14",  0, 3'b010, 64'h14, 0, 64'hFFFF_FFFF_8877_6655, 0, 2, RD1, 0, 0, 0);
        run("lwu_14", 0, 3'b110, 64'h14, 0, 64'h8877_6655, 0, 2, RD1, 0, 0, 0);

        run("sh_12", 1, 3'b001, 64'h12, 64'h1234_5678_9ABC_BEEF, 0, 0, 3, RD1, WR2,
            64'd2, 64'h8877_6655_BEEF_2211);
        run("ld_10", 0, 3'b011, 64'h10, 0, 64'h8877_6655_BEEF_2211, 0, 2, RD1, 0, 0, 0);
        run("sd_18", 1, 3'b011, 64'h18, 64'hDEAD_BEEF_0BAD_F00D, 0, 0, 2, 0, WR1,
            64'd3, 64'hDEAD_BEEF_0BAD_F00D);
        run("sb_1f", 1, 3'b000, 64'h1F, 64'hFFFF_FFFF_FFFF_FFA5, 0, 0, 3, RD1, WR2,
            64'd3, 64'hA5AD_BEEF_0BAD_F00D);
        run("sw_1c", 1, 3'b010, 64'h1C, 64'h1122_3344, 0, 0, 3, RD1, WR2,
            64'd3, 64'h1122_3344_0BAD_F00D);
        run("ld_18", 0, 3'b011, 64'h18, 0, 64'h1122_3344_0BAD_F00D, 0, 2, RD1, 0, 0, 0);
        run("sd_top", 1, 3'b011, 64'h1FF8, 64'h0123_4567_89AB_CDEF, 0, 0, 2, 0, WR1,
            64'd1023, 64'h0123_4567_89AB_CDEF);
        run("lb_1fff", 0, 3'b000, 64'h1FFF, 0, 64'h01, 0, 2, RD1, 0, 0, 0);

        run("err_lw_13",  0, 3'b010, 64'h13, 0, 0, 1, 1, 0, 0, 0, 0);
        run("err_sh_11",  1, 3'b001, 64'h11, 64'hFFFF, 0, 1, 1, 0, 0, 0, 0);
        run("err_ld_2000", 0, 3'b011, 64'h2000, 0, 0, 1, 1, 0, 0, 0, 0);
        run("err_ld_huge", 0, 3'b011, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 1, 1, 0, 0, 0, 0);
        run("err_f3_111", 0, 3'b111, 64'h10, 0, 0, 1, 1, 0, 0, 0, 0);
        run("err_sbu",    1, 3'b100, 64'h10, 64'h55, 0, 1, 1, 0, 0, 0, 0);

        // Held response with a second request waiting behind it.
        rsp_ready = 1'b0;
        req_store = 1'b0; req_funct3 = 3'b000; req_addr = 64'h17; req_wdata = '0; req_valid = 1'b1;
        @(negedge clk);
        check("stall_acc_ready", 64'(req_ready), 64'd1);
        sb.push_back('{rdata: 64'hFFFF_FFFF_FFFF_FF88, err: 1'b0});
        @(posedge clk); #1;
        req_funct3 = 3'b100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        check("stall_lat", 64'(n), 64'd2);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_valid", 64'(rsp_valid), 64'd1);
            check("stall_rdata", rsp_rdata, 64'hFFFF_FFFF_FFFF_FF88);
            check("stall_err", 64'(rsp_err), 64'd0);
            check("stall_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        sb.push_back('{rdata: 64'h88, err: 1'b0});
        @(negedge clk);
        check("resp_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("pend_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        check("pend_lat", 64'(n), 64'd2);
        @(posedge clk); #1;

        // Reset while the read half of a byte store is in flight.
        mw_snap = mw_count;
        req_store = 1'b1; req_funct3 = 3'b000; req_addr = 64'h10; req_wdata = 64'h55; req_valid = 1'b1;
        @(negedge clk);
        check("rstop_acc_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rstop_in_rd", 64'(MemRead), 64'd1);
        @(negedge clk);
        check("rstop_strobes", 64'({MemRead, MemWrite}), 64'd0);
        check("rstop_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rstop_rsp_err", 64'(rsp_err), 64'd0);
        check("rstop_rsp_rdata", rsp_rdata, 64'd0);
        check("rstop_address", address, 64'd0);
        check("rstop_wdata", WriteData, 64'd0);
        check("rstop_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstop_no_write", 64'(mw_count - mw_snap), 64'd0);
        check("rstop_word2", mem[2], 64'h8877_6655_BEEF_2211);
        @(posedge clk); #1;
        run("lb_10", 0, 3'b000, 64'h10, 0, 64'h11, 0, 2, RD1, 0, 0, 0);

        repeat (2) @(posedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
